// File: rtl/addr_tr_sched_if.sv
// Request/result handshake bundle for the segment address translator front end.
// Two requester channels plus the registered result channel toward the host.
interface addr_tr_sched_if #(
  parameter int ADDR_BITCOUNT = 64,
  parameter int TAG_BITS      = 8
);
  logic                     req0_valid;
  logic                     req0_ready;
  logic [ADDR_BITCOUNT-1:0] req0_addr;
  logic [TAG_BITS-1:0]      req0_tag;

  logic                     req1_valid;
  logic                     req1_ready;
  logic [ADDR_BITCOUNT-1:0] req1_addr;
  logic [TAG_BITS-1:0]      req1_tag;

  logic                     out_valid;
  logic                     out_ready;
  logic [ADDR_BITCOUNT-1:0] out_addr;
  logic [TAG_BITS-1:0]      out_tag;
  logic                     out_src;
  logic                     out_err;

  modport master (
    output req0_valid, req0_addr, req0_tag,
    output req1_valid, req1_addr, req1_tag,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_addr, out_tag, out_src, out_err
  );

  modport slave (
    input  req0_valid, req0_addr, req0_tag,
    input  req1_valid, req1_addr, req1_tag,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_addr, out_tag, out_src, out_err
  );
endinterface

// File: rtl/addr_tr_sched.sv
// Segment translator front end: four base registers, round-robin arbitration of two
// requesters, one registered translation per cycle with fault flagging and error count.
module addr_tr_sched #(
  parameter int ADDR_BITCOUNT = 64,
  parameter int TAG_BITS      = 8,
  parameter int ERR_CNT_BITS  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_wr_en,
  input  logic [1:0]               cfg_seg,
  input  logic [ADDR_BITCOUNT-1:0] cfg_base,
  input  logic                     cfg_clear,
  output logic [3:0]               seg_valid,
  addr_tr_sched_if.slave           bus,
  output logic [ERR_CNT_BITS-1:0]  err_cnt
);

  logic [ADDR_BITCOUNT-1:0] base_q [4];
  logic [3:0]               seg_valid_q;

  // rr_last_q holds the most recently granted port; reset to 1 so port 0 wins the first tie.
  logic                     rr_last_q, rr_last_d;
  logic                     out_valid_q, out_valid_d;
  logic [ADDR_BITCOUNT-1:0] out_addr_q, out_addr_d;
  logic [TAG_BITS-1:0]      out_tag_q, out_tag_d;
  logic                     out_src_q, out_src_d;
  logic                     out_err_q, out_err_d;
  logic [ERR_CNT_BITS-1:0]  err_cnt_q, err_cnt_d;

  logic                     slot_free;
  logic                     grant0, grant1;
  logic                     accept;
  logic [ADDR_BITCOUNT-1:0] addr_sel;
  logic [TAG_BITS-1:0]      tag_sel;
  logic [1:0]               seg;
  logic                     high_nz;
  logic                     fault;
  logic [ADDR_BITCOUNT-1:0] xlat_sum;

  always_comb begin
    slot_free = ~out_valid_q | bus.out_ready;
    grant0    = bus.req0_valid & (~bus.req1_valid | rr_last_q);
    grant1    = bus.req1_valid & ~grant0;
  end

  // Nothing is accepted while reset is asserted, regardless of the valids.
  assign bus.req0_ready = grant0 & slot_free & ~rst;
  assign bus.req1_ready = grant1 & slot_free & ~rst;

  always_comb begin
    accept   = (bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready);
    addr_sel = grant1 ? bus.req1_addr : bus.req0_addr;
    tag_sel  = grant1 ? bus.req1_tag  : bus.req0_tag;
    seg      = addr_sel[31:30];
  end

  generate
    if (ADDR_BITCOUNT > 32) begin : g_high
      assign high_nz = |addr_sel[ADDR_BITCOUNT-1:32];
    end else begin : g_no_high
      assign high_nz = 1'b0;
    end
  endgenerate

  assign fault    = high_nz | ~seg_valid_q[seg];
  assign xlat_sum = base_q[seg] + {{(ADDR_BITCOUNT-30){1'b0}}, addr_sel[29:0]};

  always_comb begin
    rr_last_d   = rr_last_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_tag_d   = out_tag_q;
    out_src_d   = out_src_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_addr_d  = fault ? '0 : xlat_sum;
      out_tag_d   = tag_sel;
      out_src_d   = grant1;
      out_err_d   = fault;
      rr_last_d   = grant1;
      if (fault && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q   <= 1'b1;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_tag_q   <= '0;
      out_src_q   <= 1'b0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      rr_last_q   <= rr_last_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_tag_q   <= out_tag_d;
      out_src_q   <= out_src_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Clear is applied before a same-cycle write, so the written segment survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) base_q[i] <= '0;
      seg_valid_q <= '0;
    end else begin
      if (cfg_clear) begin
        for (int i = 0; i < 4; i++) base_q[i] <= '0;
        seg_valid_q <= '0;
      end
      if (cfg_wr_en) begin
        base_q[cfg_seg]      <= cfg_base;
        seg_valid_q[cfg_seg] <= 1'b1;
      end
    end
  end

  assign seg_valid     = seg_valid_q;
  assign err_cnt       = err_cnt_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_err   = out_err_q;

endmodule
